chess_board_state: RTL and testbench

Parametrised, clocked chess board store with a move-apply engine. It holds every square's 5-bit piece code and accepts move commands over a valid/ready handshake. For each move it checks ownership, then applies it atomically with capture and pawn promotion, toggles the side to move and returns a status pulse. It sits between the move-generation logic, which supplies geometrically legal candidate moves, and the display/readout path.

---
 rtl/chess_board_state.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_chess_board_state.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_board_state.sv
// chess_board_state
// Clocked chess board store with a move-apply engine. Every square holds a
// 5-bit piece code {type[2:0], colour, occupied}. Moves arrive over a
// valid/ready handshake, are ownership-checked, then applied atomically with
// capture and pawn promotion. The side to move toggles and a one-cycle status
// pulse is returned. A registered readout port is independent of the engine.
//
// Ports
//   clk, reset (async, active-high), init (sync reload of start position)
//   mv_valid/mv_ready, mv_src_row/col, mv_dst_row/col : move command
//   rsp_valid, rsp_code[1:0]  : status pulse (0 ok, 1 bad src, 2 own dst, 3 range/src==dst)
//   side_to_move, move_count  : game state (count saturates at 16'hFFFF)
//   rd_row/rd_col -> rd_sq    : registered square readout
//
// Optional feature, macro CHESS_CAPTURE_LOG_EN:
//   cap_valid, cap_sq[4:0], cap_white[4:0], cap_black[4:0] capture log ports.
module chess_board_state #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int RW   = $clog2(ROWS),
  parameter int CW   = $clog2(COLS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          mv_valid,
  output logic          mv_ready,
  input  logic [RW-1:0] mv_src_row,
  input  logic [CW-1:0] mv_src_col,
  input  logic [RW-1:0] mv_dst_row,
  input  logic [CW-1:0] mv_dst_col,
  output logic          rsp_valid,
  output logic [1:0]    rsp_code,
  output logic          side_to_move,
  output logic [15:0]   move_count,
  input  logic [RW-1:0] rd_row,
  input  logic [CW-1:0] rd_col,
  output logic [4:0]    rd_sq
`ifdef CHESS_CAPTURE_LOG_EN
  ,
  output logic          cap_valid,
  output logic [4:0]    cap_sq,
  output logic [4:0]    cap_white,
  output logic [4:0]    cap_black
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_CHECK = 3'd2,
    S_WRITE = 3'd3,
    S_SKIP  = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  // Start-position square code; the back rank repeats R,N,B,Q,K,B,N,R.
  function automatic logic [4:0] start_sq(input int r, input logic [2:0] c3);
    logic [2:0] t;
    logic [4:0] sq;
    case (c3)
      3'd0, 3'd7: t = 3'b100;
      3'd1, 3'd6: t = 3'b010;
      3'd2, 3'd5: t = 3'b011;
      3'd3:       t = 3'b101;
      3'd4:       t = 3'b110;
      default:    t = 3'b000;
    endcase
    if (r == 0)             sq = {t, 2'b11};
    else if (r == 1)        sq = {3'b001, 2'b11};
    else if (r == ROWS - 2) sq = {3'b001, 2'b01};
    else if (r == ROWS - 1) sq = {t, 2'b01};
    else                    sq = 5'b00000;
    return sq;
  endfunction

  // Indices are as wide as $clog2, so non-power-of-two boards can overflow.
  function automatic logic in_range(input logic [RW-1:0] row, input logic [CW-1:0] col);
    return (int'(row) < ROWS) && (int'(col) < COLS);
  endfunction

  state_t        state_q, state_d;
  logic [4:0]    board_q [ROWS][COLS];
  logic [4:0]    board_d [ROWS][COLS];
  logic [RW-1:0] src_row_q, src_row_d, dst_row_q, dst_row_d;
  logic [CW-1:0] src_col_q, src_col_d, dst_col_q, dst_col_d;
  logic [4:0]    src_sq_q, src_sq_d;
  logic [1:0]    dst_oc_q, dst_oc_d;     // destination {colour, occupied}
  logic [1:0]    code_q, code_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_code_q, rsp_code_d;
  logic          side_q, side_d;
  logic [15:0]   count_q, count_d;
  logic          mv_ready_q, mv_ready_d;
  logic [4:0]    rd_sq_q, rd_sq_d;
  logic [4:0]    moved_sq;
`ifdef CHESS_CAPTURE_LOG_EN
  logic [4:0]    dst_sq_q, dst_sq_d;
  logic          cap_valid_q, cap_valid_d;
  logic [4:0]    cap_sq_q, cap_sq_d;
  logic [4:0]    cap_white_q, cap_white_d;
  logic [4:0]    cap_black_q, cap_black_d;
`endif

  // Register bank; asynchronous reset reloads the start position.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          board_q[r][c] <= start_sq(r, 3'(c));
        end
      end
      src_row_q   <= {RW{1'b0}};
      src_col_q   <= {CW{1'b0}};
      dst_row_q   <= {RW{1'b0}};
      dst_col_q   <= {CW{1'b0}};
      src_sq_q    <= 5'b00000;
      dst_oc_q    <= 2'b00;
      code_q      <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_code_q  <= 2'd0;
      side_q      <= 1'b0;
      count_q     <= 16'd0;
      mv_ready_q  <= 1'b1;
      rd_sq_q     <= 5'b00000;
`ifdef CHESS_CAPTURE_LOG_EN
      dst_sq_q    <= 5'b00000;
      cap_valid_q <= 1'b0;
      cap_sq_q    <= 5'b00000;
      cap_white_q <= 5'd0;
      cap_black_q <= 5'd0;
`endif
    end else begin
      state_q     <= state_d;
      board_q     <= board_d;
      src_row_q   <= src_row_d;
      src_col_q   <= src_col_d;
      dst_row_q   <= dst_row_d;
      dst_col_q   <= dst_col_d;
      src_sq_q    <= src_sq_d;
      dst_oc_q    <= dst_oc_d;
      code_q      <= code_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_code_q  <= rsp_code_d;
      side_q      <= side_d;
      count_q     <= count_d;
      mv_ready_q  <= mv_ready_d;
      rd_sq_q     <= rd_sq_d;
`ifdef CHESS_CAPTURE_LOG_EN
      dst_sq_q    <= dst_sq_d;
      cap_valid_q <= cap_valid_d;
      cap_sq_q    <= cap_sq_d;
      cap_white_q <= cap_white_d;
      cap_black_q <= cap_black_d;
`endif
    end
  end

  // Pawn reaching the far rank for its colour becomes a queen of that colour.
  always_comb begin
    moved_sq = src_sq_q;
    if ((src_sq_q[4:2] == 3'b001) &&
        ((!src_sq_q[1] && (dst_row_q == {RW{1'b0}})) ||
         (src_sq_q[1] && (int'(dst_row_q) == ROWS - 1)))) begin
      moved_sq = {3'b101, src_sq_q[1:0]};
    end else begin
      moved_sq = src_sq_q;
    end
  end

  // Move engine next-state: IDLE -> FETCH -> CHECK -> WRITE|SKIP -> RESP.
  always_comb begin
    state_d     = state_q;
    board_d     = board_q;
    src_row_d   = src_row_q;
    src_col_d   = src_col_q;
    dst_row_d   = dst_row_q;
    dst_col_d   = dst_col_q;
    src_sq_d    = src_sq_q;
    dst_oc_d    = dst_oc_q;
    code_d      = code_q;
    rsp_valid_d = 1'b0;
    rsp_code_d  = rsp_code_q;
    side_d      = side_q;
    count_d     = count_q;
`ifdef CHESS_CAPTURE_LOG_EN
    dst_sq_d    = dst_sq_q;
    cap_valid_d = 1'b0;
    cap_sq_d    = cap_sq_q;
    cap_white_d = cap_white_q;
    cap_black_d = cap_black_q;
`endif
    if (init) begin
      // init beats any in-flight move and any simultaneous mv_valid
      state_d = S_IDLE;
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          board_d[r][c] = start_sq(r, 3'(c));
        end
      end
      side_d     = 1'b0;
      count_d    = 16'd0;
      rsp_code_d = 2'd0;
`ifdef CHESS_CAPTURE_LOG_EN
      cap_sq_d    = 5'b00000;
      cap_white_d = 5'd0;
      cap_black_d = 5'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mv_valid) begin
            src_row_d = mv_src_row;
            src_col_d = mv_src_col;
            dst_row_d = mv_dst_row;
            dst_col_d = mv_dst_col;
            state_d   = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_FETCH: begin
          if (in_range(src_row_q, src_col_q)) begin
            src_sq_d = board_q[src_row_q][src_col_q];
          end else begin
            src_sq_d = 5'b00000;
          end
          if (in_range(dst_row_q, dst_col_q)) begin
            dst_oc_d = board_q[dst_row_q][dst_col_q][1:0];
`ifdef CHESS_CAPTURE_LOG_EN
            dst_sq_d = board_q[dst_row_q][dst_col_q];
`endif
          end else begin
            dst_oc_d = 2'b00;
`ifdef CHESS_CAPTURE_LOG_EN
            dst_sq_d = 5'b00000;
`endif
          end
          state_d = S_CHECK;
        end
        S_CHECK: begin
          if (!in_range(src_row_q, src_col_q) || !in_range(dst_row_q, dst_col_q) ||
              ((src_row_q == dst_row_q) && (src_col_q == dst_col_q))) begin
            code_d = 2'd3;
          end else if (!src_sq_q[0] || (src_sq_q[1] != side_q)) begin
            code_d = 2'd1;
          end else if (dst_oc_q[0] && (dst_oc_q[1] == side_q)) begin
            code_d = 2'd2;
          end else begin
            code_d = 2'd0;
          end
          if (code_d == 2'd0) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_SKIP;
          end
        end
        S_WRITE: begin
          board_d[dst_row_q][dst_col_q] = moved_sq;
          board_d[src_row_q][src_col_q] = 5'b00000;
          side_d = ~side_q;
          if (count_q != 16'hFFFF) begin
            count_d = count_q + 16'd1;
          end else begin
            count_d = count_q;
          end
`ifdef CHESS_CAPTURE_LOG_EN
          if (dst_sq_q[0]) begin
            cap_valid_d = 1'b1;
            cap_sq_d    = dst_sq_q;
            if (dst_sq_q[1]) begin
              cap_black_d = (cap_black_q == 5'h1F) ? cap_black_q : cap_black_q + 5'd1;
            end else begin
              cap_white_d = (cap_white_q == 5'h1F) ? cap_white_q : cap_white_q + 5'd1;
            end
          end else begin
            cap_valid_d = 1'b0;
          end
`endif
          rsp_valid_d = 1'b1;
          rsp_code_d  = code_q;
          state_d     = S_RESP;
        end
        S_SKIP: begin
          rsp_valid_d = 1'b1;
          rsp_code_d  = code_q;
          state_d     = S_RESP;
        end
        S_RESP: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    mv_ready_d = (state_d == S_IDLE);
  end

  // Readout: registered copy of the addressed square, zero when out of range.
  always_comb begin
    if (in_range(rd_row, rd_col)) begin
      rd_sq_d = board_q[rd_row][rd_col];
    end else begin
      rd_sq_d = 5'b00000;
    end
  end

  assign mv_ready     = mv_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_code     = rsp_code_q;
  assign side_to_move = side_q;
  assign move_count   = count_q;
  assign rd_sq        = rd_sq_q;
`ifdef CHESS_CAPTURE_LOG_EN
  assign cap_valid    = cap_valid_q;
  assign cap_sq       = cap_sq_q;
  assign cap_white    = cap_white_q;
  assign cap_black    = cap_black_q;
`endif

endmodule

// File: tb/tb_chess_board_state.sv
module tb_chess_board_state;

  logic        clk;
  logic        reset;
  logic        init;
  logic        mv_valid;
  logic        mv_ready;
  logic [2:0]  mv_src_row, mv_src_col, mv_dst_row, mv_dst_col;
  logic        rsp_valid;
  logic [1:0]  rsp_code;
  logic        side_to_move;
  logic [15:0] move_count;
  logic [2:0]  rd_row, rd_col;
  logic [4:0]  rd_sq;
`ifdef CHESS_CAPTURE_LOG_EN
  logic        cap_valid;
  logic [4:0]  cap_sq, cap_white, cap_black;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [1:0] exp_q [$];
  logic [4:0] mdl [8][8];

  chess_board_state #(.ROWS(8), .COLS(8)) dut (
    .clk(clk), .reset(reset), .init(init),
    .mv_valid(mv_valid), .mv_ready(mv_ready),
    .mv_src_row(mv_src_row), .mv_src_col(mv_src_col),
    .mv_dst_row(mv_dst_row), .mv_dst_col(mv_dst_col),
    .rsp_valid(rsp_valid), .rsp_code(rsp_code),
    .side_to_move(side_to_move), .move_count(move_count),
    .rd_row(rd_row), .rd_col(rd_col), .rd_sq(rd_sq)
`ifdef CHESS_CAPTURE_LOG_EN
    , .cap_valid(cap_valid), .cap_sq(cap_sq), .cap_white(cap_white), .cap_black(cap_black)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  function automatic void model_start();
    logic [4:0] back_w [8];
    back_w = '{5'b10001, 5'b01001, 5'b01101, 5'b10101, 5'b11001, 5'b01101, 5'b01001, 5'b10001};
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) mdl[r][c] = 5'b00000;
    for (int c = 0; c < 8; c++) begin
      mdl[7][c] = back_w[c];
      mdl[6][c] = 5'b00101;
      mdl[1][c] = 5'b00111;
      mdl[0][c] = back_w[c] | 5'b00010;
    end
  endfunction

  task automatic read_sq(input int r, input int c, output logic [4:0] v);
    rd_row = 3'(r);
    rd_col = 3'(c);
    @(posedge clk); #1;
    v = rd_sq;
  endtask

  // Issue one move and report the response seen, its latency after the accept edge
  task automatic do_move(input int sr, input int sc, input int dr, input int dc,
                         output logic [1:0] code, output int lat, output bit seen,
                         output logic capv, output logic [4:0] capsq);
    int w;
    w = 0;
    while (!mv_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    mv_src_row = 3'(sr); mv_src_col = 3'(sc);
    mv_dst_row = 3'(dr); mv_dst_col = 3'(dc);
    mv_valid = 1'b1;
    @(posedge clk); #1;
    mv_valid = 1'b0;
    seen = 1'b0; lat = 0; code = 2'd0; capv = 1'b0; capsq = 5'b00000;
    while (!seen && lat < 20) begin
      @(posedge clk); #1; lat++;
      if (rsp_valid) begin
        seen = 1'b1;
        code = rsp_code;
`ifdef CHESS_CAPTURE_LOG_EN
        capv = cap_valid;
        capsq = cap_sq;
`endif
      end
    end
  endtask

  task automatic test_reset();
    logic [4:0] v;
    n_vec++; if (rd_sq !== 5'b00000) begin n_err++; $display("FAIL reset_rd_sq: got %b want 00000", rd_sq); end
    n_vec++; if (mv_ready !== 1'b1) begin n_err++; $display("FAIL reset_mv_ready: got %b want 1", mv_ready); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_vec++; if (rsp_code !== 2'd0) begin n_err++; $display("FAIL reset_rsp_code: got %0d want 0", rsp_code); end
    n_vec++; if (side_to_move !== 1'b0) begin n_err++; $display("FAIL reset_side: got %b want 0", side_to_move); end
    n_vec++; if (move_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", move_count); end
    reset = 1'b0;
    @(posedge clk); #1;
    model_start();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        read_sq(r, c, v);
        n_vec++;
        if (v !== mdl[r][c]) begin n_err++; $display("FAIL reset_sq r%0d c%0d: got %b want %b", r, c, v, mdl[r][c]); end
      end
  endtask

  task automatic test_basic_move();
    logic [1:0] code, e; int lat; bit seen; logic capv; logic [4:0] capsq, v;
    exp_q.push_back(2'd0);
    do_move(6, 4, 4, 4, code, lat, seen, capv, capsq);
    e = exp_q.pop_front();
    n_vec++; if (!seen || code !== e) begin n_err++; $display("FAIL basic_code: got %0d (seen %0d) want %0d", code, seen, e); end
    n_vec++; if (lat != 3) begin n_err++; $display("FAIL basic_latency: got %0d want 3", lat); end
    mdl[4][4] = 5'b00101; mdl[6][4] = 5'b00000;
    read_sq(4, 4, v);
    n_vec++; if (v !== mdl[4][4]) begin n_err++; $display("FAIL basic_dst: got %b want %b", v, mdl[4][4]); end
    read_sq(6, 4, v);
    n_vec++; if (v !== mdl[6][4]) begin n_err++; $display("FAIL basic_src: got %b want %b", v, mdl[6][4]); end
    n_vec++; if (side_to_move !== 1'b1) begin n_err++; $display("FAIL basic_side: got %b want 1", side_to_move); end
    n_vec++; if (move_count !== 16'd1) begin n_err++; $display("FAIL basic_count: got %0d want 1", move_count); end
  endtask

  task automatic test_errors();
    int tbl [4][5];
    logic [1:0] code, e; int lat; bit seen; logic capv; logic [4:0] capsq, v;
    tbl = '{'{6, 0, 5, 0, 1}, '{0, 0, 1, 0, 2}, '{3, 3, 3, 3, 3}, '{3, 3, 4, 4, 1}};
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(2'(tbl[i][4]));
      do_move(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], code, lat, seen, capv, capsq);
      e = exp_q.pop_front();
      n_vec++; if (!seen || code !== e) begin n_err++; $display("FAIL err_code[%0d]: got %0d (seen %0d) want %0d", i, code, seen, e); end
      n_vec++; if (lat != 3) begin n_err++; $display("FAIL err_latency[%0d]: got %0d want 3", i, lat); end
    end
    n_vec++; if (side_to_move !== 1'b1) begin n_err++; $display("FAIL err_side: got %b want 1", side_to_move); end
    n_vec++; if (move_count !== 16'd1) begin n_err++; $display("FAIL err_count: got %0d want 1", move_count); end
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        read_sq(r, c, v);
        n_vec++;
        if (v !== mdl[r][c]) begin n_err++; $display("FAIL err_board r%0d c%0d: got %b want %b", r, c, v, mdl[r][c]); end
      end
  endtask

  task automatic test_promotion();
    int tbl [5][4];
    logic [4:0] exp_cap [5];
    logic [1:0] code, e; int lat; bit seen; logic capv; logic [4:0] capsq, v;
    tbl = '{'{1, 1, 3, 1}, '{6, 1, 1, 1}, '{1, 7, 2, 7}, '{1, 1, 0, 0}, '{1, 6, 7, 6}};
    exp_cap = '{5'b00000, 5'b00000, 5'b00000, 5'b10011, 5'b01001};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(2'd0);
      do_move(tbl[i][0], tbl[i][1], tbl[i][2], tbl[i][3], code, lat, seen, capv, capsq);
      e = exp_q.pop_front();
      n_vec++; if (!seen || code !== e) begin n_err++; $display("FAIL promo_code[%0d]: got %0d (seen %0d) want %0d", i, code, seen, e); end
`ifdef CHESS_CAPTURE_LOG_EN
      n_vec++; if (capv !== exp_cap[i][0]) begin n_err++; $display("FAIL promo_cap_valid[%0d]: got %b want %b", i, capv, exp_cap[i][0]); end
      if (exp_cap[i][0]) begin
        n_vec++; if (capsq !== exp_cap[i]) begin n_err++; $display("FAIL promo_cap_sq[%0d]: got %b want %b", i, capsq, exp_cap[i]); end
      end
`endif
    end
    mdl[1][1] = 5'b00000; mdl[3][1] = 5'b00111; mdl[6][1] = 5'b00000;
    mdl[1][7] = 5'b00000; mdl[2][7] = 5'b00111;
    mdl[0][0] = 5'b10101; mdl[1][6] = 5'b00000; mdl[7][6] = 5'b10111;
    read_sq(0, 0, v);
    n_vec++; if (v !== mdl[0][0]) begin n_err++; $display("FAIL promo_white_queen: got %b want %b", v, mdl[0][0]); end
    read_sq(7, 6, v);
    n_vec++; if (v !== mdl[7][6]) begin n_err++; $display("FAIL promo_black_queen: got %b want %b", v, mdl[7][6]); end
    read_sq(1, 1, v);
    n_vec++; if (v !== mdl[1][1]) begin n_err++; $display("FAIL promo_src: got %b want %b", v, mdl[1][1]); end
    read_sq(3, 1, v);
    n_vec++; if (v !== mdl[3][1]) begin n_err++; $display("FAIL promo_plain: got %b want %b", v, mdl[3][1]); end
    n_vec++; if (side_to_move !== 1'b0) begin n_err++; $display("FAIL promo_side: got %b want 0", side_to_move); end
    n_vec++; if (move_count !== 16'd6) begin n_err++; $display("FAIL promo_count: got %0d want 6", move_count); end
`ifdef CHESS_CAPTURE_LOG_EN
    n_vec++; if (cap_black !== 5'd1) begin n_err++; $display("FAIL promo_cap_black: got %0d want 1", cap_black); end
    n_vec++; if (cap_white !== 5'd1) begin n_err++; $display("FAIL promo_cap_white: got %0d want 1", cap_white); end
`endif
  endtask

  task automatic test_init_abort();
    logic [4:0] v; int w; bit got_rsp;
    w = 0;
    while (!mv_ready && w < 20) begin @(posedge clk); #1; w++; end
    mv_src_row = 3'd6; mv_src_col = 3'd2; mv_dst_row = 3'd5; mv_dst_col = 3'd2;
    mv_valid = 1'b1;
    @(posedge clk); #1;         // FETCH
    mv_valid = 1'b0;
    @(posedge clk); #1;         // CHECK
    init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    n_vec++; if (mv_ready !== 1'b1) begin n_err++; $display("FAIL init_mv_ready: got %b want 1", mv_ready); end
    n_vec++; if (move_count !== 16'd0) begin n_err++; $display("FAIL init_count: got %0d want 0", move_count); end
    n_vec++; if (side_to_move !== 1'b0) begin n_err++; $display("FAIL init_side: got %b want 0", side_to_move); end
`ifdef CHESS_CAPTURE_LOG_EN
    n_vec++; if (cap_black !== 5'd0 || cap_white !== 5'd0) begin n_err++; $display("FAIL init_cap_counts: got %0d/%0d want 0/0", cap_white, cap_black); end
`endif
    got_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) got_rsp = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++; if (got_rsp !== 1'b0) begin n_err++; $display("FAIL init_no_rsp: got %b want 0", got_rsp); end
    model_start();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        read_sq(r, c, v);
        n_vec++;
        if (v !== mdl[r][c]) begin n_err++; $display("FAIL init_board r%0d c%0d: got %b want %b", r, c, v, mdl[r][c]); end
      end
    // init and mv_valid together: init wins, move is dropped
    mv_valid = 1'b1; init = 1'b1;
    @(posedge clk); #1;
    mv_valid = 1'b0; init = 1'b0;
    n_vec++; if (mv_ready !== 1'b1) begin n_err++; $display("FAIL init_vs_valid_ready: got %b want 1", mv_ready); end
    got_rsp = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) got_rsp = 1'b1;
      @(posedge clk); #1;
    end
    n_vec++; if (got_rsp !== 1'b0) begin n_err++; $display("FAIL init_vs_valid_rsp: got %b want 0", got_rsp); end
    n_vec++; if (move_count !== 16'd0) begin n_err++; $display("FAIL init_vs_valid_count: got %0d want 0", move_count); end
  endtask

  task automatic test_back_to_back();
    int mv [4][4];
    int acc_q [$];
    int cyc, idx, last_acc, n_rsp, exp_acc;
    logic [1:0] e;
    logic acc_now;
    logic [4:0] v;
    mv = '{'{6, 0, 5, 0}, '{1, 0, 2, 0}, '{6, 1, 5, 1}, '{1, 1, 2, 1}};
    cyc = 0; idx = 0; last_acc = -100; n_rsp = 0;
    mv_src_row = 3'(mv[0][0]); mv_src_col = 3'(mv[0][1]);
    mv_dst_row = 3'(mv[0][2]); mv_dst_col = 3'(mv[0][3]);
    mv_valid = 1'b1;
    while (n_rsp < 4 && cyc < 100) begin
      n_vec++;
      if (mv_ready !== ((cyc - last_acc) >= 5)) begin
        n_err++; $display("FAIL bb_ready cyc%0d: got %b want %b", cyc, mv_ready, ((cyc - last_acc) >= 5));
      end
      acc_now = mv_ready && mv_valid;
      @(posedge clk); #1;
      if (acc_now) begin
        if (last_acc >= 0) begin
          n_vec++; if (cyc - last_acc != 5) begin n_err++; $display("FAIL bb_spacing: got %0d want 5", cyc - last_acc); end
        end
        last_acc = cyc;
        acc_q.push_back(cyc);
        exp_q.push_back(2'd0);
        idx++;
        if (idx < 4) begin
          mv_src_row = 3'(mv[idx][0]); mv_src_col = 3'(mv[idx][1]);
          mv_dst_row = 3'(mv[idx][2]); mv_dst_col = 3'(mv[idx][3]);
        end else begin
          mv_valid = 1'b0;
        end
      end
      cyc++;
      if (rsp_valid) begin
        n_rsp++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++; $display("FAIL bb_unexpected_rsp: got rsp at cyc%0d want none", cyc);
        end else begin
          e = exp_q.pop_front();
          exp_acc = acc_q.pop_front();
          if (rsp_code !== e) begin n_err++; $display("FAIL bb_code: got %0d want %0d", rsp_code, e); end
          n_vec++; if (cyc != exp_acc + 4) begin n_err++; $display("FAIL bb_latency: got cyc%0d want cyc%0d", cyc, exp_acc + 4); end
        end
      end
    end
    mv_valid = 1'b0;
    n_vec++; if (n_rsp != 4) begin n_err++; $display("FAIL bb_timeout: got %0d responses want 4", n_rsp); end
    mdl[5][0] = 5'b00101; mdl[6][0] = 5'b00000; mdl[2][0] = 5'b00111; mdl[1][0] = 5'b00000;
    mdl[5][1] = 5'b00101; mdl[6][1] = 5'b00000; mdl[2][1] = 5'b00111; mdl[1][1] = 5'b00000;
    for (int r = 1; r < 7; r++)
      for (int c = 0; c < 2; c++) begin
        read_sq(r, c, v);
        n_vec++;
        if (v !== mdl[r][c]) begin n_err++; $display("FAIL bb_board r%0d c%0d: got %b want %b", r, c, v, mdl[r][c]); end
      end
    n_vec++; if (side_to_move !== 1'b0) begin n_err++; $display("FAIL bb_side: got %b want 0", side_to_move); end
    n_vec++; if (move_count !== 16'd4) begin n_err++; $display("FAIL bb_count: got %0d want 4", move_count); end
  endtask

  task automatic test_async_reset();
    logic [4:0] v; int w; bit got_rsp;
    w = 0;
    while (!mv_ready && w < 20) begin @(posedge clk); #1; w++; end
    mv_src_row = 3'd6; mv_src_col = 3'd3; mv_dst_row = 3'd5; mv_dst_col = 3'd3;
    mv_valid = 1'b1;
    @(posedge clk); #1;         // FETCH
    mv_valid = 1'b0;
    @(posedge clk); #1;         // CHECK
    @(posedge clk); #1;         // WRITE
    #2 reset = 1'b1;
    #1;
    n_vec++; if (mv_ready !== 1'b1) begin n_err++; $display("FAIL areset_ready: got %b want 1", mv_ready); end
    n_vec++; if (move_count !== 16'd0) begin n_err++; $display("FAIL areset_count: got %0d want 0", move_count); end
    n_vec++; if (rd_sq !== 5'b00000) begin n_err++; $display("FAIL areset_rd_sq: got %b want 00000", rd_sq); end
    n_vec++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL areset_rsp: got %b want 0", rsp_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    got_rsp = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) got_rsp = 1'b1;
    end
    n_vec++; if (got_rsp !== 1'b0) begin n_err++; $display("FAIL areset_no_rsp: got %b want 0", got_rsp); end
    model_start();
    read_sq(6, 3, v);
    n_vec++; if (v !== mdl[6][3]) begin n_err++; $display("FAIL areset_src: got %b want %b", v, mdl[6][3]); end
    read_sq(5, 3, v);
    n_vec++; if (v !== mdl[5][3]) begin n_err++; $display("FAIL areset_dst: got %b want %b", v, mdl[5][3]); end
    read_sq(5, 0, v);
    n_vec++; if (v !== mdl[5][0]) begin n_err++; $display("FAIL areset_prev: got %b want %b", v, mdl[5][0]); end
  endtask

  initial begin
    reset = 1'b1; init = 1'b0; mv_valid = 1'b0;
    mv_src_row = 3'd0; mv_src_col = 3'd0; mv_dst_row = 3'd0; mv_dst_col = 3'd0;
    rd_row = 3'd0; rd_col = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic_move();
    test_errors();
    test_promotion();
    test_init_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
